// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
//
// Purpose: shares one I2C write controller between two requesters. A
// transaction is accepted from the winning requester and handed to the
// controller. It is re-issued after a NACK, with an idle gap before each
// retry, up to MAX_RETRY times. The WAIT state is abandoned after
// TIMEOUT_CYCLES cycles with no ctl_done. The outcome is returned to the
// owner as a one-cycle done/error pulse.
//
// Ports:
//   clock_25                 - only clock, rising edge
//   reset                    - synchronous, active-high
//   req0_valid / req1_valid  - requester holds a transaction
//   req0_data / req1_data    - {slave_addr, reg_addr, payload}
//   req0_ready / req1_ready  - transaction accepted this cycle (combinational)
//   req0_done / req1_done    - one-cycle completion pulse
//   req0_error / req1_error  - failure flag, meaningful only with done
//   ctl_start                - one-cycle launch pulse to the controller
//   ctl_data                 - transaction held for the controller
//   ctl_done / ctl_nack      - controller completion and slave NACK
//   grant                    - one-hot bus owner, 00 when idle
//   busy                     - high whenever the arbiter is not idle

module i2c_req_arbiter #(
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [23:0] req0_data,
  input  logic [23:0] req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        req0_done,
  output logic        req1_done,
  output logic        req0_error,
  output logic        req1_error,
  output logic        ctl_start,
  output logic [23:0] ctl_data,
  input  logic        ctl_done,
  input  logic        ctl_nack,
  output logic [1:0]  grant,
  output logic        busy
);

  // Counter widths are sized to hold the parameter value itself.
  localparam int RW = (MAX_RETRY < 1)      ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GW = (GAP_CYCLES < 1)     ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TMO_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} state_t;

  state_t          state_q;
  logic [23:0]     ctlData_q;
  logic [1:0]      grant_q;
  logic            ctlStart_q;
  logic            done0_q, done1_q, err0_q, err1_q;
  logic            lastServed_q;   // 1: req1 was served last
  logic [RW-1:0]   retry_q;
  logic [GW-1:0]   gap_q;
  logic [TW-1:0]   tmo_q;

  logic win0, win1;

  // Round-robin: on contention the requester not served last wins.
  assign win0 = req0_valid & (~req1_valid | lastServed_q);
  assign win1 = req1_valid & (~req0_valid | ~lastServed_q);

  assign req0_ready = (state_q == IDLE) & ~reset & win0;
  assign req1_ready = (state_q == IDLE) & ~reset & win1;

  assign ctl_start  = ctlStart_q;
  assign ctl_data   = ctlData_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_error = err0_q;
  assign req1_error = err1_q;

  // Single FSM process. Pulse outputs default low each cycle and are set on
  // the edge that enters the state they belong to, so ctl_start is high
  // exactly while in ISSUE and done/error exactly while in RESP.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q      <= IDLE;
      ctlData_q    <= '0;
      grant_q      <= '0;
      ctlStart_q   <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      lastServed_q <= 1'b1;
      retry_q      <= '0;
      gap_q        <= '0;
      tmo_q        <= '0;
    end else begin
      ctlStart_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win0 | win1) begin
            ctlData_q  <= win0 ? req0_data : req1_data;
            grant_q    <= {win1, win0};
            retry_q    <= '0;
            ctlStart_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // ctl_done is examined first so it wins over a same-cycle expiry.
          if (ctl_done) begin
            if (ctl_nack && (retry_q < RETRY_MAX)) begin
              retry_q <= retry_q + 1'b1;
              gap_q   <= '0;
              if (GAP_CYCLES == 0) begin
                ctlStart_q <= 1'b1;
                state_q    <= ISSUE;
              end else begin
                state_q <= GAP;
              end
            end else begin
              done0_q <= grant_q[0];
              done1_q <= grant_q[1];
              err0_q  <= grant_q[0] & ctl_nack;
              err1_q  <= grant_q[1] & ctl_nack;
              state_q <= RESP;
            end
          end else if (tmo_q >= TMO_LAST) begin
            done0_q <= grant_q[0];
            done1_q <= grant_q[1];
            err0_q  <= grant_q[0];
            err1_q  <= grant_q[1];
            state_q <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q >= GAP_LAST) begin
            ctlStart_q <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        RESP: begin
          lastServed_q <= grant_q[1];
          grant_q      <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter
//
// Purpose: self-checking bench for i2c_req_arbiter. Each transaction's
// expected outcome is derived from the arbitration and retry rules: who
// wins, how many attempts happen, whether an error results, and in which
// cycle each pulse appears. Directed cases cover the corner conditions, and
// a randomized run follows them.
//
// Ports: none (top-level bench).

module tb_i2c_req_arbiter;

  localparam int MAX_RETRY  = 3;
  localparam int GAP_CYCLES = 7;
  localparam int TMO        = 100;

  logic        clock_25 = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        req0_done, req1_done;
  logic        req0_error, req1_error;
  logic        ctl_start;
  logic [23:0] ctl_data;
  logic        ctl_done, ctl_nack;
  logic [1:0]  grant;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int startCount  = 0;
  int lastServed  = 1;

  i2c_req_arbiter #(
    .MAX_RETRY      (MAX_RETRY),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_done  (req0_done),
    .req1_done  (req1_done),
    .req0_error (req0_error),
    .req1_error (req1_error),
    .ctl_start  (ctl_start),
    .ctl_data   (ctl_data),
    .ctl_done   (ctl_done),
    .ctl_nack   (ctl_nack),
    .grant      (grant),
    .busy       (busy)
  );

  // 25 MHz clock.
  always #20 clock_25 = ~clock_25;

  // One comparison: count it, and report and count any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Count every launch pulse, and require that no requester ever sees ready
  // while the arbiter is busy.
  always @(negedge clock_25) begin
    if (ctl_start === 1'b1) startCount++;
    if (busy === 1'b1) checkOutput("readyWhileBusy", 32'({req0_ready, req1_ready}), 32'd0);
  end

  // Runs one transaction from the IDLE negedge to the first IDLE negedge
  // after it. The controller NACKs the first nNacks attempts and ACKs the
  // next one. Each response comes in WAIT cycle 'delay'. With noDone set the
  // controller never answers.
  task automatic applyStimulus(input bit v0, input bit v1,
                               input logic [23:0] d0, input logic [23:0] d1,
                               input int nNacks, input int delay, input bit noDone);
    int          win;
    int          attempts;
    int          startBase;
    bit          expErr;
    logic [23:0] expData;

    startBase  = startCount;
    req0_data  = d0;
    req1_data  = d1;
    req0_valid = v0;
    req1_valid = v1;

    win      = (v0 && v1) ? ((lastServed == 1) ? 0 : 1) : (v0 ? 0 : 1);
    expData  = (win == 0) ? d0 : d1;
    attempts = noDone ? 1 : (((nNacks < MAX_RETRY) ? nNacks : MAX_RETRY) + 1);
    expErr   = noDone || (nNacks > MAX_RETRY);

    #1;
    checkOutput("ready0", 32'(req0_ready), 32'(win == 0));
    checkOutput("ready1", 32'(req1_ready), 32'(win == 1));

    @(negedge clock_25);
    if (win == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
    checkOutput("firstStart", 32'(ctl_start), 32'd1);
    checkOutput("ctlData", 32'(ctl_data), 32'(expData));
    checkOutput("grant", 32'(grant), (win == 0) ? 32'd1 : 32'd2);

    for (int a = 0; a < attempts; a++) begin
      if (noDone) begin
        repeat (TMO) @(negedge clock_25);
        checkOutput("noEarlyTimeout", 32'({req0_done, req1_done}), 32'd0);
        @(negedge clock_25);
      end else begin
        repeat (delay) @(negedge clock_25);
        ctl_done = 1'b1;
        ctl_nack = (a < nNacks);
        @(negedge clock_25);
        ctl_done = 1'b0;
        ctl_nack = 1'b0;
        if (a < attempts - 1) begin
          checkOutput("gapQuiet", 32'({ctl_start, req0_done, req1_done}), 32'd0);
          repeat (GAP_CYCLES) @(negedge clock_25);
          checkOutput("retryStart", 32'(ctl_start), 32'd1);
          checkOutput("retryData", 32'(ctl_data), 32'(expData));
        end
      end
    end

    checkOutput("done0", 32'(req0_done), 32'(win == 0));
    checkOutput("done1", 32'(req1_done), 32'(win == 1));
    checkOutput("error0", 32'(req0_error), 32'(win == 0 && expErr));
    checkOutput("error1", 32'(req1_error), 32'(win == 1 && expErr));
    checkOutput("heldData", 32'(ctl_data), 32'(expData));

    @(negedge clock_25);
    checkOutput("idleAfter", 32'({grant, busy, req0_done, req1_done}), 32'd0);
    checkOutput("startCount", 32'(startCount - startBase), 32'(attempts));
    lastServed = win;
  endtask

  // Directed cases first, then a randomized run, then reset mid-transaction.
  initial begin
    int sel;

    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 24'hABCDEF;
    req1_data  = 24'h123456;
    ctl_done   = 1'b0;
    ctl_nack   = 1'b0;

    repeat (3) @(negedge clock_25);
    checkOutput("resetReady", 32'({req0_ready, req1_ready}), 32'd0);
    checkOutput("resetCtrl", 32'({ctl_start, grant, busy, req0_done, req1_done,
                                  req0_error, req1_error}), 32'd0);
    checkOutput("resetData", 32'(ctl_data), 32'd0);
    reset = 1'b0;

    $display("[TB] round-robin from reset");
    applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 0, 3, 1'b0);
    applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 0, 5, 1'b0);
    applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 0, 2, 1'b0);

    $display("[TB] single request, ACK after 20 cycles");
    applyStimulus(1'b1, 1'b0, 24'h724100, 24'($urandom), 0, 20, 1'b0);

    $display("[TB] NACK on every attempt");
    applyStimulus(1'b0, 1'b1, 24'($urandom), 24'($urandom), 4, 5, 1'b0);

    $display("[TB] NACK then ACK");
    applyStimulus(1'b1, 1'b0, 24'($urandom), 24'($urandom), 1, 4, 1'b0);

    $display("[TB] ACK on the last allowed attempt");
    applyStimulus(1'b0, 1'b1, 24'($urandom), 24'($urandom), MAX_RETRY, 2, 1'b0);

    $display("[TB] timeout, then ACK in the expiry cycle");
    applyStimulus(1'b1, 1'b0, 24'($urandom), 24'($urandom), 0, 1, 1'b1);
    applyStimulus(1'b1, 1'b0, 24'($urandom), 24'($urandom), 0, TMO, 1'b0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(1, 3));
      applyStimulus(sel[0], sel[1], 24'($urandom), 24'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 30)), 1'b0);
    end

    // Leave req0 as last served so a lost reset of the priority shows up.
    applyStimulus(1'b1, 1'b0, 24'($urandom), 24'($urandom), 0, 3, 1'b0);

    $display("[TB] reset during WAIT");
    req0_valid = 1'b1;
    req0_data  = 24'($urandom);
    @(negedge clock_25);
    req0_valid = 1'b0;
    repeat (4) @(negedge clock_25);
    reset = 1'b1;
    repeat (2) @(negedge clock_25);
    checkOutput("midReset", 32'({ctl_start, grant, busy, req0_done, req1_done,
                                 req0_error, req1_error, req0_ready, req1_ready}), 32'd0);
    checkOutput("midResetData", 32'(ctl_data), 32'd0);
    reset    = 1'b0;
    ctl_done = 1'b1;
    @(negedge clock_25);
    ctl_done = 1'b0;
    checkOutput("lateDoneIgnored", 32'({grant, busy, req0_done, req1_done, ctl_start}), 32'd0);
    lastServed = 1;
    applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 0, 3, 1'b0);

    repeat (2) @(negedge clock_25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
